// File: rtl/datapath_ctrl.sv
// Sequencer for the 8-bit accumulate datapath: loads operand a, then runs
// the b/c/d ALU triple for a programmable number of passes and captures the result.
module datapath_ctrl #(
  parameter int PASS_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic [2:0]        op_b,
  input  logic [2:0]        op_c,
  input  logic [2:0]        op_d,
  input  logic [PASS_W-1:0] passes,
  input  logic [7:0]        dp_s,
  input  logic              dp_ovf,
  output logic              s2,
  output logic              s1,
  output logic              s0,
  output logic              f2,
  output logic              f1,
  output logic              f0,
  output logic              busy,
  output logic              done,
  output logic [7:0]        result,
  output logic              ovf_sticky,
  output logic [PASS_W-1:0] pass_left
);

  typedef enum logic [2:0] {IDLE, LOAD, OP_B, OP_C, OP_D, FIN} state_e;

  typedef struct packed {
    logic [2:0] b;
    logic [2:0] c;
    logic [2:0] d;
  } ops_t;

  state_e            state_q, state_d;
  ops_t              ops_q, ops_d;
  logic [PASS_W-1:0] pass_q, pass_d;
  logic [7:0]        result_q, result_d;
  logic              ovf_q, ovf_d;
  logic              done_q, done_d;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of its peers, independent of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      ops_q    <= '0;
      pass_q   <= '0;
      result_q <= '0;
      ovf_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      ops_q    <= ops_d;
      pass_q   <= pass_d;
      result_q <= result_d;
      ovf_q    <= ovf_d;
      done_q   <= done_d;
    end
  end

  // NOTE: every signal gets a default before the case so no path can leave
  // it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d  = state_q;
    ops_d    = ops_q;
    pass_d   = pass_q;
    result_d = result_q;
    ovf_d    = ovf_q;
    done_d   = 1'b0;
    if (state_q != IDLE && abort) begin
      // Abort keeps the partial overflow flag and the previous result.
      state_d = IDLE;
      pass_d  = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start && !abort) begin
            state_d = LOAD;
            ops_d   = '{b: op_b, c: op_c, d: op_d};
            pass_d  = (passes == '0) ? PASS_W'(1) : passes;
            ovf_d   = 1'b0;
          end
        end
        LOAD: state_d = OP_B;
        OP_B: begin
          state_d = OP_C;
          ovf_d   = ovf_q | dp_ovf;
        end
        OP_C: begin
          state_d = OP_D;
          ovf_d   = ovf_q | dp_ovf;
        end
        OP_D: begin
          ovf_d = ovf_q | dp_ovf;
          if (pass_q > PASS_W'(1)) begin
            pass_d  = pass_q - PASS_W'(1);
            state_d = OP_B;
          end else begin
            state_d = FIN;
          end
        end
        FIN: begin
          result_d = dp_s;
          done_d   = 1'b1;
          pass_d   = '0;
          state_d  = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Moore decode of the datapath selects from state and the latched ops.
  always_comb begin
    s0         = 1'b1;
    {s2, s1}   = 2'b00;
    {f2, f1, f0} = 3'b000;
    unique case (state_q)
      OP_B: begin
        s0           = 1'b0;
        {f2, f1, f0} = ops_q.b;
      end
      OP_C: begin
        s0           = 1'b0;
        {s2, s1}     = 2'b01;
        {f2, f1, f0} = ops_q.c;
      end
      OP_D: begin
        s0           = 1'b0;
        {s2, s1}     = 2'b10;
        {f2, f1, f0} = ops_q.d;
      end
      default: ;
    endcase
  end

  assign busy       = (state_q != IDLE);
  assign done       = done_q;
  assign result     = result_q;
  assign ovf_sticky = ovf_q;
  assign pass_left  = pass_q;

endmodule

// File: tb/tb_datapath_ctrl.sv
// Directed self-checking bench for datapath_ctrl; dp_s/dp_ovf are driven
// directly as stimulus in place of the real datapath.
module tb_datapath_ctrl;

  logic       clk;
  logic       reset;
  logic       start;
  logic       abort;
  logic [2:0] op_b, op_c, op_d;
  logic [3:0] passes;
  logic [7:0] dp_s;
  logic       dp_ovf;
  logic       s2, s1, s0, f2, f1, f0;
  logic       busy, done;
  logic [7:0] result;
  logic       ovf_sticky;
  logic [3:0] pass_left;
  logic [7:0] obs;

  int vec_cnt = 0;
  int err_cnt = 0;

  datapath_ctrl #(.PASS_W(4)) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .op_b(op_b), .op_c(op_c), .op_d(op_d), .passes(passes),
    .dp_s(dp_s), .dp_ovf(dp_ovf),
    .s2(s2), .s1(s1), .s0(s0), .f2(f2), .f1(f1), .f0(f0),
    .busy(busy), .done(done), .result(result),
    .ovf_sticky(ovf_sticky), .pass_left(pass_left)
  );

  assign obs = {s2, s1, s0, f2, f1, f0, busy, done};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected {s2,s1,s0,f,busy,done} at step k after the start edge:
  // 0=LOAD, 1..3p=op steps, 3p+1=FIN, 3p+2=IDLE with done.
  function automatic logic [7:0] exp_vec(int k, int p, logic [2:0] ob, logic [2:0] oc,
                                         logic [2:0] od);
    if (k == 0) return 8'b001_000_10;
    if (k <= 3 * p) begin
      case ((k - 1) % 3)
        0:       return {3'b000, ob, 2'b10};
        1:       return {3'b010, oc, 2'b10};
        default: return {3'b100, od, 2'b10};
      endcase
    end
    if (k == 3 * p + 1) return 8'b001_000_10;
    return 8'b001_000_01;
  endfunction

  function automatic logic [3:0] exp_pass(int k, int p);
    if (k == 0) return 4'(p);
    if (k <= 3 * p) return 4'(p - (k - 1) / 3);
    if (k == 3 * p + 1) return 4'd1;
    return 4'd0;
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; abort = 1'b0; passes = 4'd1;
    op_b = 3'b000; op_c = 3'b000; op_d = 3'b000; dp_s = 8'h00; dp_ovf = 1'b0;
    repeat (2) @(posedge clk);
    #3 reset = 1'b0;
    #1;
    vec_cnt++;
    if ({obs, result, ovf_sticky, pass_left} !== {8'b001_000_00, 8'h00, 1'b0, 4'h0}) begin
      err_cnt++;
      $display("FAIL reset_async: got %b/%h/%b/%h want 00100000/00/0/0",
               obs, result, ovf_sticky, pass_left);
    end
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      vec_cnt++;
      if ({obs, result, ovf_sticky, pass_left} !== {8'b001_000_00, 8'h00, 1'b0, 4'h0}) begin
        err_cnt++;
        $display("FAIL reset_hold[%0d]: got %b/%h/%b/%h want 00100000/00/0/0",
                 i, obs, result, ovf_sticky, pass_left);
      end
    end
    reset = 1'b1;
    cyc();
  endtask

  // Runs one full sequence and checks every cycle through the done pulse.
  task automatic test_passes(input logic [3:0] pin, input int p, input logic [2:0] ob,
                             input logic [2:0] oc, input logic [2:0] od,
                             input logic [7:0] fin_val);
    passes = pin; op_b = ob; op_c = oc; op_d = od;
    start = 1'b1;
    cyc();
    start = 1'b0;
    for (int k = 0; k <= 3 * p + 2; k++) begin
      vec_cnt++;
      if ({obs, pass_left} !== {exp_vec(k, p, ob, oc, od), exp_pass(k, p)}) begin
        err_cnt++;
        $display("FAIL seq_p%0d step %0d: got %b/%0d want %b/%0d", p, k, obs, pass_left,
                 exp_vec(k, p, ob, oc, od), exp_pass(k, p));
      end
      dp_s = (k == 3 * p + 1) ? fin_val : 8'h00;
      if (k < 3 * p + 2) cyc();
    end
    vec_cnt++;
    if (result !== fin_val) begin
      err_cnt++;
      $display("FAIL seq_p%0d result: got %h want %h", p, result, fin_val);
    end
    cyc();
    vec_cnt++;
    if ({busy, done} !== 2'b00) begin
      err_cnt++;
      $display("FAIL seq_p%0d done_width: got busy/done %b want 00", p, {busy, done});
    end
  endtask

  task automatic test_abort();
    passes = 4'd1; op_b = 3'b001; op_c = 3'b010; op_d = 3'b011;
    start = 1'b1;
    cyc();
    start = 1'b0;
    cyc();
    cyc();
    vec_cnt++;
    if (obs !== 8'b010_010_10) begin
      err_cnt++;
      $display("FAIL abort_in_opc: got %b want 01001010", obs);
    end
    abort = 1'b1;
    cyc();
    abort = 1'b0;
    vec_cnt++;
    if ({obs, pass_left, result} !== {8'b001_000_00, 4'd0, 8'h5A}) begin
      err_cnt++;
      $display("FAIL abort_idle: got %b/%0d/%h want 00100000/0/5a", obs, pass_left, result);
    end
    for (int i = 0; i < 3; i++) begin
      cyc();
      vec_cnt++;
      if ({busy, done, result} !== {2'b00, 8'h5A}) begin
        err_cnt++;
        $display("FAIL abort_no_done[%0d]: got %b/%h want 00/5a", i, {busy, done}, result);
      end
    end
    start = 1'b1; abort = 1'b1;
    cyc();
    start = 1'b0; abort = 1'b0;
    vec_cnt++;
    if (busy !== 1'b0) begin
      err_cnt++;
      $display("FAIL start_abort_idle: got busy %b want 0", busy);
    end
    start = 1'b1;
    cyc();
    start = 1'b0;
    repeat (4) cyc();
    dp_s = 8'hEE;
    vec_cnt++;
    if (obs !== 8'b001_000_10) begin
      err_cnt++;
      $display("FAIL abort_fin_state: got %b want 00100010", obs);
    end
    abort = 1'b1;
    cyc();
    abort = 1'b0; dp_s = 8'h00;
    vec_cnt++;
    if ({busy, done, result} !== {2'b00, 8'h5A}) begin
      err_cnt++;
      $display("FAIL abort_in_fin: got %b/%h want 00/5a", {busy, done}, result);
    end
  endtask

  task automatic test_ovf_sticky();
    passes = 4'd2; op_b = 3'b100; op_c = 3'b001; op_d = 3'b010;
    start = 1'b1;
    cyc();
    start = 1'b0;
    for (int k = 0; k <= 8; k++) begin
      vec_cnt++;
      if ({ovf_sticky, done} !== {(k >= 6), (k == 8)}) begin
        err_cnt++;
        $display("FAIL ovf step %0d: got ovf/done %b want %b", k, {ovf_sticky, done},
                 {(k >= 6), (k == 8)});
      end
      dp_ovf = (k == 5);
      if (k < 8) cyc();
    end
    dp_ovf = 1'b0;
    start = 1'b1;
    cyc();
    start = 1'b0;
    vec_cnt++;
    if ({obs, ovf_sticky} !== {8'b001_000_10, 1'b0}) begin
      err_cnt++;
      $display("FAIL ovf_clear: got %b/%b want 00100010/0", obs, ovf_sticky);
    end
    abort = 1'b1;
    cyc();
    abort = 1'b0;
  endtask

  task automatic test_busy_start();
    passes = 4'd1; op_b = 3'b001; op_c = 3'b010; op_d = 3'b011;
    start = 1'b1;
    cyc();
    start = 1'b0;
    cyc();
    start = 1'b1; op_b = 3'b111; op_c = 3'b111; op_d = 3'b111; passes = 4'd5;
    cyc();
    start = 1'b0;
    for (int k = 2; k <= 5; k++) begin
      vec_cnt++;
      if ({obs, pass_left} !== {exp_vec(k, 1, 3'b001, 3'b010, 3'b011), exp_pass(k, 1)}) begin
        err_cnt++;
        $display("FAIL busy_start step %0d: got %b/%0d want %b/%0d", k, obs, pass_left,
                 exp_vec(k, 1, 3'b001, 3'b010, 3'b011), exp_pass(k, 1));
      end
      dp_s = (k == 4) ? 8'h3C : 8'h00;
      if (k < 5) cyc();
    end
    vec_cnt++;
    if (result !== 8'h3C) begin
      err_cnt++;
      $display("FAIL busy_start result: got %h want 3c", result);
    end
    cyc();
  endtask

  task automatic test_back_to_back();
    passes = 4'd1; op_b = 3'b100; op_c = 3'b101; op_d = 3'b110;
    start = 1'b1;
    cyc();
    for (int k = 0; k <= 5; k++) begin
      vec_cnt++;
      if (obs !== exp_vec(k, 1, 3'b100, 3'b101, 3'b110)) begin
        err_cnt++;
        $display("FAIL b2b step %0d: got %b want %b", k, obs,
                 exp_vec(k, 1, 3'b100, 3'b101, 3'b110));
      end
      dp_s = (k == 4) ? 8'h77 : 8'h00;
      cyc();
    end
    start = 1'b0;
    vec_cnt++;
    if ({obs, result} !== {8'b001_000_10, 8'h77}) begin
      err_cnt++;
      $display("FAIL b2b restart: got %b/%h want 00100010/77", obs, result);
    end
    cyc();
  endtask

  task automatic test_reset_mid();
    vec_cnt++;
    if (obs !== 8'b000_100_10) begin
      err_cnt++;
      $display("FAIL reset_mid_pre: got %b want 00010010", obs);
    end
    #3 reset = 1'b0;
    #1;
    vec_cnt++;
    if ({obs, result, ovf_sticky, pass_left} !== {8'b001_000_00, 8'h00, 1'b0, 4'h0}) begin
      err_cnt++;
      $display("FAIL reset_mid: got %b/%h/%b/%h want 00100000/00/0/0",
               obs, result, ovf_sticky, pass_left);
    end
    @(posedge clk);
    #1 reset = 1'b1;
    cyc();
    vec_cnt++;
    if ({busy, done} !== 2'b00) begin
      err_cnt++;
      $display("FAIL reset_mid_after: got %b want 00", {busy, done});
    end
  endtask

  initial begin
    test_reset();
    test_passes(4'd1, 1, 3'b001, 3'b010, 3'b011, 8'h5A);
    test_abort();
    test_passes(4'd3, 3, 3'b101, 3'b110, 3'b111, 8'hC3);
    test_passes(4'd0, 1, 3'b011, 3'b000, 3'b110, 8'h81);
    test_ovf_sticky();
    test_busy_start();
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
